// File: rtl/comp_stream_rx.sv
// comp_stream_rx: receiver for the multiplexed SAR comparator bitstream.
// It collects NBITS decisions MSB first, tags each word with the channel that
// was selected at conv_start, and queues it in a first-word-fall-through FIFO
// behind a valid/ready handshake.
// Optional build macro COMP_STREAM_RX_CONV_CNT_EN adds the 16-bit conv_cnt
// output, which counts completed conversions (stored or dropped).
module comp_stream_rx #(
    parameter int NBITS      = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int CHW        = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CHW-1:0]   chan_sel,
    input  logic             conv_start,
    input  logic             bit_valid,
    input  logic             comp_in,
    output logic [NBITS-1:0] out_data,
    output logic [CHW-1:0]   out_chan,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overflow,
    input  logic             clr_ovf
`ifdef COMP_STREAM_RX_CONV_CNT_EN
    ,
    output logic [15:0]      conv_cnt
`endif
);

    localparam int CNTW = $clog2(NBITS + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PUSH    = 2'd2
    } state_t;

    typedef struct packed {
        logic [CHW-1:0]   chan;
        logic [NBITS-1:0] data;
    } entry_t;

    state_t           state_q, state_d;
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic [CHW-1:0]   chan_q, chan_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    entry_t           mem_q [FIFO_DEPTH];
    entry_t           head;

    logic start_req;
    logic last_bit;
    logic push_active;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic do_write;
    logic drop;

    // A new conversion can only begin while the receiver is enabled.
    assign start_req = enable && conv_start;
    assign last_bit  = (count_q == CNTW'(NBITS - 1));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: flops take non-blocking assignments so every register samples
        // the pre-edge value of its neighbours, independent of block order.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state: restart on conv_start, leave COLLECT after the last bit,
    // PUSH lasts one cycle, and a low enable aborts to IDLE.
    always_comb begin
        // NOTE: the default assignment up front keeps every path assigned, so
        // no latch is inferred when a branch below does not mention state_d.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_req) state_d = COLLECT;
            end
            COLLECT: begin
                if (!enable)                   state_d = IDLE;
                else if (conv_start)           state_d = COLLECT;
                else if (bit_valid && last_bit) state_d = PUSH;
            end
            PUSH: begin
                state_d = start_req ? COLLECT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: busy while a word is in flight, push only if still enabled.
    always_comb begin
        busy        = (state_q != IDLE);
        push_active = (state_q == PUSH) && enable;
    end

    // Word assembly: conv_start always wins over a same-cycle bit, which is
    // therefore discarded; bits shift in MSB first.
    always_comb begin
        shreg_d = shreg_q;
        count_d = count_q;
        chan_d  = chan_q;
        if (start_req) begin
            shreg_d = '0;
            count_d = '0;
            chan_d  = chan_sel;
        end else if ((state_q == COLLECT) && enable && bit_valid) begin
            shreg_d = {shreg_q[NBITS-2:0], comp_in};
            count_d = count_q + CNTW'(1);
        end
    end

    // FIFO status; the extra pointer bit separates full from empty.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop        = !fifo_empty && out_ready;
        do_write   = push_active && (!fifo_full || pop);
        drop       = push_active && fifo_full && !pop;
    end

    // Pointer advance and sticky overflow; a drop beats a same-cycle clear.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, do_write};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
        overflow_d = overflow_q;
        if (clr_ovf) overflow_d = 1'b0;
        if (drop)    overflow_d = 1'b1;
    end

    // Control and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q    <= '0;
            count_q    <= '0;
            chan_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            count_q    <= count_d;
            chan_q     <= chan_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage written during PUSH.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; the pointers define which
        // entries are meaningful, and the output is masked while empty.
        if (do_write) mem_q[wr_ptr_q[AW-1:0]] <= entry_t'({chan_q, shreg_q});
    end

    // Head of FIFO, forced to zero while empty.
    always_comb begin
        head      = mem_q[rd_ptr_q[AW-1:0]];
        out_valid = !fifo_empty;
        out_data  = fifo_empty ? '0 : head.data;
        out_chan  = fifo_empty ? '0 : head.chan;
        overflow  = overflow_q;
    end

`ifdef COMP_STREAM_RX_CONV_CNT_EN
    logic [15:0] conv_cnt_q, conv_cnt_d;

    // Completed-conversion counter; wraps naturally at 16 bits.
    always_comb begin
        conv_cnt_d = conv_cnt_q + {15'd0, push_active};
    end

    // Completed-conversion counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) conv_cnt_q <= '0;
        else        conv_cnt_q <= conv_cnt_d;
    end

    assign conv_cnt = conv_cnt_q;
`endif

endmodule

// File: tb/tb_comp_stream_rx.sv
// tb_comp_stream_rx: self-checking bench for comp_stream_rx.
// A table of per-cycle vectors covers the basic conversion, hand sequences
// cover the FIFO and abort corners, and a randomized run is compared every
// cycle against a queue-based reference model.
module tb_comp_stream_rx;

    localparam int NBITS = 12;
    localparam int DEPTH = 4;
    localparam int CHW   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic [CHW-1:0]   chan_sel = '0;
    logic             conv_start = 1'b0;
    logic             bit_valid = 1'b0;
    logic             comp_in = 1'b0;
    logic [NBITS-1:0] out_data;
    logic [CHW-1:0]   out_chan;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             busy;
    logic             overflow;
    logic             clr_ovf = 1'b0;
`ifdef COMP_STREAM_RX_CONV_CNT_EN
    logic [15:0]      conv_cnt;
`endif

    comp_stream_rx #(.NBITS(NBITS), .FIFO_DEPTH(DEPTH), .CHW(CHW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .chan_sel   (chan_sel),
        .conv_start (conv_start),
        .bit_valid  (bit_valid),
        .comp_in    (comp_in),
        .out_data   (out_data),
        .out_chan   (out_chan),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
`ifdef COMP_STREAM_RX_CONV_CNT_EN
        ,
        .conv_cnt   (conv_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [CHW-1:0]   chan;
        logic [NBITS-1:0] data;
    } word_t;

    int               m_state;   // 0 idle, 1 collecting, 2 push cycle
    int               m_nbits;
    logic [NBITS-1:0] m_word;
    logic [CHW-1:0]   m_chan;
    word_t            m_q[$];
    bit               m_ovf;
`ifdef COMP_STREAM_RX_CONV_CNT_EN
    logic [15:0]      m_cnt;
`endif

    task automatic model_reset();
        m_state = 0;
        m_nbits = 0;
        m_word  = '0;
        m_chan  = '0;
        m_q.delete();
        m_ovf   = 1'b0;
`ifdef COMP_STREAM_RX_CONV_CNT_EN
        m_cnt   = '0;
`endif
    endtask

    task automatic model_start();
        m_chan  = chan_sel;
        m_word  = '0;
        m_nbits = 0;
    endtask

    // Advance the model across one clock edge using the current inputs.
    task automatic model_step();
        bit pop, push, store;
        int nxt;
        pop   = (m_q.size() > 0) && out_ready;
        push  = (m_state == 2) && enable;
        store = push && ((m_q.size() < DEPTH) || pop);
        if (pop)   void'(m_q.pop_front());
        if (store) m_q.push_back(word_t'({m_chan, m_word}));
        if (clr_ovf)         m_ovf = 1'b0;
        if (push && !store)  m_ovf = 1'b1;
`ifdef COMP_STREAM_RX_CONV_CNT_EN
        if (push) m_cnt = m_cnt + 16'd1;
`endif
        nxt = m_state;
        case (m_state)
            0: if (enable && conv_start) begin model_start(); nxt = 1; end
            1: begin
                if (!enable) nxt = 0;
                else if (conv_start) model_start();
                else if (bit_valid) begin
                    m_word  = (m_word << 1) | NBITS'(comp_in);
                    m_nbits = m_nbits + 1;
                    if (m_nbits == NBITS) nxt = 2;
                end
            end
            default: begin
                if (enable && conv_start) begin model_start(); nxt = 1; end
                else nxt = 0;
            end
        endcase
        m_state = nxt;
    endtask

    task automatic compare();
        word_t h;
        h = (m_q.size() > 0) ? m_q[0] : '0;
        check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        check("out_data",  32'(out_data),  32'(h.data));
        check("out_chan",  32'(out_chan),  32'(h.chan));
        check("busy",      32'(busy),      32'(m_state != 0));
        check("overflow",  32'(overflow),  32'(m_ovf));
`ifdef COMP_STREAM_RX_CONV_CNT_EN
        check("conv_cnt",  32'(conv_cnt),  32'(m_cnt));
`endif
    endtask

    // One clock: model follows the inputs, DUT sampled 1 ns after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic quiet();
        conv_start = 1'b0;
        bit_valid  = 1'b0;
        comp_in    = 1'b0;
        clr_ovf    = 1'b0;
    endtask

    task automatic send_bits(input logic [NBITS-1:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            bit_valid = 1'b1;
            comp_in   = w[NBITS-1-i];
            tick();
        end
        bit_valid = 1'b0;
    endtask

    // conv_start cycle followed by NBITS bits; leaves the DUT in PUSH.
    task automatic do_conv(input logic [CHW-1:0] ch, input logic [NBITS-1:0] w);
        enable     = 1'b1;
        conv_start = 1'b1;
        chan_sel   = ch;
        bit_valid  = 1'b0;
        tick();
        conv_start = 1'b0;
        send_bits(w, NBITS);
    endtask

    task automatic do_reset();
        quiet();
        enable    = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #2;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic             en, cs, bv, ci, rdy;
        logic [CHW-1:0]   ch;
        logic             exp_valid, exp_busy;
        logic [NBITS-1:0] exp_data;
        logic [CHW-1:0]   exp_chan;
    } vec_t;

    vec_t vecs[15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NBITS-1:0] pat;
        logic [NBITS-1:0] w;

        // Basic conversion: chan 5, bits 1010_1100_1111.
        pat = 12'hACF;
        vecs[0] = '{en:1, cs:1, bv:0, ci:0, rdy:0, ch:5,
                    exp_valid:0, exp_busy:1, exp_data:0, exp_chan:0};
        for (int i = 0; i < NBITS; i++)
            vecs[1+i] = '{en:1, cs:0, bv:1, ci:pat[NBITS-1-i], rdy:0, ch:5,
                          exp_valid:0, exp_busy:1, exp_data:0, exp_chan:0};
        vecs[13] = '{en:1, cs:0, bv:0, ci:0, rdy:0, ch:5,
                     exp_valid:1, exp_busy:0, exp_data:12'hACF, exp_chan:5};
        vecs[14] = '{en:1, cs:0, bv:0, ci:0, rdy:1, ch:5,
                     exp_valid:0, exp_busy:0, exp_data:0, exp_chan:0};

        // Reset values.
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data",  32'(out_data),  32'd0);
        check("rst out_chan",  32'(out_chan),  32'd0);
        check("rst busy",      32'(busy),      32'd0);
        check("rst overflow",  32'(overflow),  32'd0);
        rst_n = 1'b1;
        tick();

        // Table-driven basic conversion and latency.
        foreach (vecs[i]) begin
            enable     = vecs[i].en;
            conv_start = vecs[i].cs;
            bit_valid  = vecs[i].bv;
            comp_in    = vecs[i].ci;
            out_ready  = vecs[i].rdy;
            chan_sel   = vecs[i].ch;
            tick();
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d busy", i),      32'(busy),      32'(vecs[i].exp_busy));
            check($sformatf("vec%0d out_data", i),  32'(out_data),  32'(vecs[i].exp_data));
            check($sformatf("vec%0d out_chan", i),  32'(out_chan),  32'(vecs[i].exp_chan));
        end
        quiet();
        out_ready = 1'b0;

        // Five back-to-back conversions into a 4-deep FIFO: fifth is dropped.
        for (int t = 0; t < 5; t++) do_conv(CHW'(t), NBITS'($urandom));
        quiet();
        tick();
        check("ovf set after drop", 32'(overflow), 32'd1);
        check("head tag 0", 32'(out_chan), 32'd0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf cleared", 32'(overflow), 32'd0);
        for (int t = 0; t < 4; t++) begin
            check($sformatf("drain tag %0d", t), 32'(out_chan), 32'(t));
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        check("drained empty", 32'(out_valid), 32'd0);

        // Full FIFO with a pop in the PUSH cycle: word stored, no overflow.
        for (int t = 0; t < 5; t++) do_conv(CHW'(t), NBITS'($urandom));
        quiet();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("push+pop ovf", 32'(overflow), 32'd0);
        check("push+pop head", 32'(out_chan), 32'd1);
        for (int t = 1; t < 5; t++) begin
            check($sformatf("full drain tag %0d", t), 32'(out_chan), 32'(t));
            check($sformatf("full drain valid %0d", t), 32'(out_valid), 32'd1);
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        check("full drained", 32'(out_valid), 32'd0);

        // Restart mid-conversion with a new channel; the restart bit is lost.
        w = NBITS'($urandom);
        enable = 1'b1; conv_start = 1'b1; chan_sel = 4'd2;
        tick();
        conv_start = 1'b0;
        send_bits(NBITS'($urandom), 6);
        conv_start = 1'b1; chan_sel = 4'd9; bit_valid = 1'b1; comp_in = 1'b1;
        tick();
        quiet();
        send_bits(w, NBITS);
        tick();
        check("restart tag", 32'(out_chan), 32'd9);
        check("restart data", 32'(out_data), 32'(w));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("restart single word", 32'(out_valid), 32'd0);

        // Abort via enable after 7 bits, then one full conversion.
        do_reset();
        w = NBITS'($urandom);
        enable = 1'b1; conv_start = 1'b1; chan_sel = 4'd6;
        tick();
        conv_start = 1'b0;
        send_bits(NBITS'($urandom), 7);
        enable = 1'b0;
        tick();
        check("abort idle", 32'(busy), 32'd0);
        do_conv(4'd3, w);
        quiet();
        tick();
        check("abort word data", 32'(out_data), 32'(w));
        check("abort word tag", 32'(out_chan), 32'd3);
`ifdef COMP_STREAM_RX_CONV_CNT_EN
        check("abort conv_cnt", 32'(conv_cnt), 32'd1);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("abort single word", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-COLLECT with two words queued.
        do_conv(4'd3, NBITS'($urandom));
        do_conv(4'd7, NBITS'($urandom));
        quiet();
        tick();
        enable = 1'b1; conv_start = 1'b1; chan_sel = 4'd1;
        tick();
        conv_start = 1'b0;
        send_bits(NBITS'($urandom), 5);
        check("pre-reset valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst busy",      32'(busy),      32'd0);
        check("async rst overflow",  32'(overflow),  32'd0);
        check("async rst out_data",  32'(out_data),  32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bit_valid = 1'($urandom);
            comp_in   = 1'($urandom);
            tick();
        end
        quiet();

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            enable     = ($urandom_range(0, 99) < 97);
            conv_start = ($urandom_range(0, 99) < 5);
            chan_sel   = CHW'($urandom);
            bit_valid  = ($urandom_range(0, 99) < 60);
            comp_in    = 1'($urandom);
            out_ready  = ($urandom_range(0, 99) < 35);
            clr_ovf    = ($urandom_range(0, 99) < 3);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
